// File: rtl/vga_frame_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : vga_frame_checker                                                |
// | Brief   : In-line VGA stream monitor: per-frame CRC-32, geometry check and |
// |           frame counting. Optional macro VGA_FRAME_CHECKER_EXPECT_EN adds  |
// |           an expected-CRC comparator.                                      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module vga_frame_checker #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int RW        = 5,
  parameter int GW        = 6,
  parameter int BW        = 5,
  parameter int CW        = 12,
  parameter int VSYNC_POL = 0,
  parameter int FCW       = 16
) (
  input  logic              i_pclk,
  input  logic              i_reset,
  input  logic              i_vsync,
  input  logic              i_hactive,
  input  logic              i_vactive,
  input  logic [RW-1:0]     i_red,
  input  logic [GW-1:0]     i_green,
  input  logic [BW-1:0]     i_blue,
`ifdef VGA_FRAME_CHECKER_EXPECT_EN
  input  logic [31:0]       i_expect_crc,
  output logic              o_crc_mismatch,
`endif
  output logic              o_frame_done,
  output logic [31:0]       o_frame_crc,
  output logic [CW-1:0]     o_frame_lines,
  output logic              o_line_err,
  output logic              o_frame_err,
  output logic [FCW-1:0]    o_frame_count
);

  localparam int          c_PW       = RW + GW + BW;
  localparam logic [31:0] c_POLY     = 32'h04C11DB7;
  localparam logic [31:0] c_CRC_INIT = 32'hFFFF_FFFF;

  typedef enum logic [0:0] {
    S_WAIT_SYNC = 1'b0,
    S_CAPTURE   = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_vs_act;
  logic            r_pv;
  logic [31:0]     r_crc;
  logic [CW-1:0]   r_pix_cnt;
  logic [CW-1:0]   r_line_cnt;
  logic            r_line_bad;
  logic            r_frame_done;
  logic [31:0]     r_frame_crc;
  logic [CW-1:0]   r_frame_lines;
  logic            r_line_err;
  logic            r_frame_err;
  logic [FCW-1:0]  r_frame_count;

  logic            w_vs_act;
  logic            w_boundary;
  logic            w_pv;
  logic            w_close;
  logic            w_latch;
  logic [c_PW-1:0] w_pix;
  logic [31:0]     w_crc_upd;
  logic [CW-1:0]   w_lines_end;
  logic            w_bad_end;
  logic [31:0]     w_crc_nxt;
  logic [CW-1:0]   w_pix_nxt;
  logic [CW-1:0]   w_line_nxt;
  logic            w_bad_nxt;

  // Whole pixel word absorbed MSB first in a single cycle.
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [c_PW-1:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = c_PW - 1; i >= 0; i--) begin
      c = (c[31] ^ d[i]) ? ((c << 1) ^ c_POLY) : (c << 1);
    end
    return c;
  endfunction

  assign w_vs_act   = (VSYNC_POL != 0) ? i_vsync : ~i_vsync;
  assign w_boundary = w_vs_act & ~r_vs_act;
  assign w_pv       = i_hactive & i_vactive;
  // A line still open when the frame ends is closed into the ending frame.
  assign w_close    = r_pv & (~w_pv | w_boundary);
  assign w_latch    = (r_state == S_CAPTURE) & w_boundary;
  assign w_pix      = {i_red, i_green, i_blue};
  assign w_crc_upd  = crc_step(w_boundary ? c_CRC_INIT : r_crc, w_pix);

  assign w_lines_end = (w_close && (r_line_cnt != '1)) ? r_line_cnt + CW'(1) : r_line_cnt;
  assign w_bad_end   = r_line_bad | (w_close && (r_pix_cnt != CW'(H_ACTIVE)));

  always_comb begin
    w_state_nxt = r_state;
    if (w_boundary) begin
      w_state_nxt = S_CAPTURE;
    end
  end

  always_comb begin
    w_crc_nxt  = r_crc;
    w_pix_nxt  = r_pix_cnt;
    w_line_nxt = r_line_cnt;
    w_bad_nxt  = r_line_bad;
    if (w_boundary) begin
      w_crc_nxt  = w_pv ? w_crc_upd : c_CRC_INIT;
      w_pix_nxt  = w_pv ? CW'(1) : '0;
      w_line_nxt = '0;
      w_bad_nxt  = 1'b0;
    end else if (r_state == S_CAPTURE) begin
      if (w_pv) begin
        w_crc_nxt = w_crc_upd;
        w_pix_nxt = (r_pix_cnt != '1) ? r_pix_cnt + CW'(1) : r_pix_cnt;
      end
      if (w_close) begin
        w_pix_nxt  = '0;
        w_line_nxt = w_lines_end;
        w_bad_nxt  = w_bad_end;
      end
    end
  end

  always_ff @(posedge i_pclk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_WAIT_SYNC;
      r_vs_act      <= 1'b1;
      r_pv          <= 1'b0;
      r_crc         <= c_CRC_INIT;
      r_pix_cnt     <= '0;
      r_line_cnt    <= '0;
      r_line_bad    <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_crc   <= '0;
      r_frame_lines <= '0;
      r_line_err    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_vs_act     <= w_vs_act;
      r_pv         <= w_pv;
      r_crc        <= w_crc_nxt;
      r_pix_cnt    <= w_pix_nxt;
      r_line_cnt   <= w_line_nxt;
      r_line_bad   <= w_bad_nxt;
      r_frame_done <= w_latch;
      if (w_latch) begin
        r_frame_crc   <= r_crc;
        r_frame_lines <= w_lines_end;
        r_line_err    <= w_bad_end;
        r_frame_err   <= (w_lines_end != CW'(V_ACTIVE));
        r_frame_count <= r_frame_count + FCW'(1);
      end
    end
  end

  assign o_frame_done  = r_frame_done;
  assign o_frame_crc   = r_frame_crc;
  assign o_frame_lines = r_frame_lines;
  assign o_line_err    = r_line_err;
  assign o_frame_err   = r_frame_err;
  assign o_frame_count = r_frame_count;

`ifdef VGA_FRAME_CHECKER_EXPECT_EN
  logic r_crc_mismatch;

  always_ff @(posedge i_pclk or posedge i_reset) begin
    if (i_reset) begin
      r_crc_mismatch <= 1'b0;
    end else if (w_latch) begin
      r_crc_mismatch <= (r_crc != i_expect_crc);
    end
  end

  assign o_crc_mismatch = r_crc_mismatch;

`ifndef SYNTHESIS
  always @(posedge i_pclk) begin
    if (!i_reset && w_latch && (r_crc != i_expect_crc)) begin
      $display("vga_frame_checker: frame %0d crc %08h expected %08h",
               r_frame_count + FCW'(1), r_crc, i_expect_crc);
    end
  end
`endif
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_checker.sv
`default_nettype none
// Bench for vga_frame_checker: small-geometry frames driven against a
// byte-table CRC model that tracks frames as pixel and line-length lists.
module tb_vga_frame_checker;
`ifdef VGA_FRAME_CHECKER_EXPECT_EN
  localparam int RW = 8, GW = 8, BW = 8, VSYNC_POL = 1;
`else
  localparam int RW = 5, GW = 6, BW = 5, VSYNC_POL = 0;
`endif
  localparam int PW = RW + GW + BW;
  localparam int H = 16, V = 12, CW = 12, FCW = 16;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  typedef logic [PW-1:0] pq_t[$];

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           vs_act = 1'b0;
  logic           hactive = 1'b0;
  logic           vactive = 1'b0;
  logic [PW-1:0]  pix = '0;
  logic           vsync;
  logic           o_frame_done, o_line_err, o_frame_err;
  logic [31:0]    o_frame_crc;
  logic [CW-1:0]  o_frame_lines;
  logic [FCW-1:0] o_frame_count;
`ifdef VGA_FRAME_CHECKER_EXPECT_EN
  logic [31:0]    exp_crc_in = '0;
  logic           o_crc_mismatch;
  logic           e_mis = 1'b0;
`endif

  assign vsync = (VSYNC_POL != 0) ? vs_act : ~vs_act;

  always #5 clk = ~clk;

  vga_frame_checker #(
    .H_ACTIVE(H), .V_ACTIVE(V), .RW(RW), .GW(GW), .BW(BW),
    .CW(CW), .VSYNC_POL(VSYNC_POL), .FCW(FCW)
  ) dut (
    .i_pclk        (clk),
    .i_reset       (rst),
    .i_vsync       (vsync),
    .i_hactive     (hactive),
    .i_vactive     (vactive),
    .i_red         (pix[PW-1 -: RW]),
    .i_green       (pix[BW +: GW]),
    .i_blue        (pix[BW-1:0]),
`ifdef VGA_FRAME_CHECKER_EXPECT_EN
    .i_expect_crc  (exp_crc_in),
    .o_crc_mismatch(o_crc_mismatch),
`endif
    .o_frame_done  (o_frame_done),
    .o_frame_crc   (o_frame_crc),
    .o_frame_lines (o_frame_lines),
    .o_line_err    (o_line_err),
    .o_frame_err   (o_frame_err),
    .o_frame_count (o_frame_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] tbl [256];

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    return (crc << 8) ^ tbl[crc[31:24] ^ b];
  endfunction

  function automatic logic [31:0] crc_words(input pq_t q);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (q[k]) begin
      for (int j = PW/8 - 1; j >= 0; j--) c = crc_byte(c, q[k][j*8 +: 8]);
    end
    return c;
  endfunction

  function automatic logic [PW-1:0] pixval(input int mode, input int l, input int c, input bit flip);
    logic [PW-1:0] v;
    if (mode == 0) v = '0;
    else v = PW'(l * 977 + c * 131 + 17) ^ PW'((l * c) << 5);
    if (flip && l == 3 && c == 2) v[0] = ~v[0];
    return v;
  endfunction

  function automatic logic [31:0] frame_crc_pre(input int nl, input int shortl, input int mode);
    pq_t q;
    for (int l = 0; l < nl; l++)
      for (int c = 0; c < ((l == shortl) ? H - 1 : H); c++) q.push_back(pixval(mode, l, c, 1'b0));
    return crc_words(q);
  endfunction

  pq_t            m_pix;
  int             m_lines[$];
  int             m_cur = 0;
  bit             m_armed = 0, m_ppv = 0, m_pvs = 0, m_pv, m_bnd, m_bad;
  logic           e_done = 0, e_lerr = 0, e_ferr = 0;
  logic [31:0]    e_crc = 0;
  logic [CW-1:0]  e_lines = 0;
  logic [FCW-1:0] e_count = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_armed = 0; m_pix.delete(); m_lines.delete(); m_cur = 0; m_ppv = 0; m_pvs = vs_act;
      e_done = 0; e_crc = 0; e_lines = 0; e_lerr = 0; e_ferr = 0; e_count = 0;
`ifdef VGA_FRAME_CHECKER_EXPECT_EN
      e_mis = 0;
`endif
    end else begin
      m_pv  = hactive & vactive;
      m_bnd = vs_act & ~m_pvs;
      e_done = 0;
      if (m_bnd) begin
        if (m_armed) begin
          if (m_ppv) m_lines.push_back(m_cur);
          m_bad = 0;
          foreach (m_lines[k]) if (m_lines[k] != H) m_bad = 1;
          e_crc   = crc_words(m_pix);
          e_lines = CW'(m_lines.size());
          e_lerr  = m_bad;
          e_ferr  = (m_lines.size() != V);
          e_count = e_count + 1'b1;
          e_done  = 1;
`ifdef VGA_FRAME_CHECKER_EXPECT_EN
          e_mis = (e_crc != exp_crc_in);
`endif
        end
        m_armed = 1; m_pix.delete(); m_lines.delete(); m_cur = 0;
        if (m_pv) begin m_pix.push_back(pix); m_cur = 1; end
      end else if (m_armed) begin
        if (m_pv) begin m_pix.push_back(pix); m_cur++; end
        else if (m_ppv) begin m_lines.push_back(m_cur); m_cur = 0; end
      end
      m_ppv = m_pv;
      m_pvs = vs_act;
    end
  end

  always @(negedge clk) begin
    #1;
    if (rst) begin
      chk("rst_done",  o_frame_done, 0);
      chk("rst_crc",   o_frame_crc, 0);
      chk("rst_lines", o_frame_lines, 0);
      chk("rst_errs",  {o_line_err, o_frame_err}, 0);
      chk("rst_count", o_frame_count, 0);
`ifdef VGA_FRAME_CHECKER_EXPECT_EN
      chk("rst_mis",   o_crc_mismatch, 0);
`endif
    end else begin
      chk("done",  o_frame_done, e_done);
      chk("crc",   o_frame_crc, e_crc);
      chk("lines", o_frame_lines, e_lines);
      chk("lerr",  o_line_err, e_lerr);
      chk("ferr",  o_frame_err, e_ferr);
      chk("count", o_frame_count, e_count);
`ifdef VGA_FRAME_CHECKER_EXPECT_EN
      chk("mis",   o_crc_mismatch, e_mis);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic vs, input logic ha, input logic va, input logic [PW-1:0] p);
    vs_act = vs; hactive = ha; vactive = va; pix = p;
    @(negedge clk);
  endtask

  task automatic boundary(input bit bpix);
    step(1'b1, bpix, bpix, bpix ? {PW{1'b1}} : {PW{1'b0}});
  endtask

  task automatic body(input int nl, input int shortl, input int mode, input int rstl, input bit flip);
    step(1'b1, 1'b0, 1'b0, '0);
    repeat (2) step(1'b0, 1'b0, 1'b0, '0);
    for (int l = 0; l < nl; l++) begin
      if (l == rstl) begin
        rst = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b0, '0);
        rst = 1'b0;
        repeat (2) step(1'b0, 1'b0, 1'b0, '0);
        return;
      end
      for (int c = 0; c < ((l == shortl) ? H - 1 : H); c++)
        step(1'b0, 1'b1, 1'b1, pixval(mode, l, c, flip));
      repeat (4) step(1'b0, 1'b0, 1'b1, '0);
    end
    repeat (3) step(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic lit(input string tag, input logic done, input int lines, input logic lerr,
                     input logic ferr, input int count);
    chk({tag, "_done"},  o_frame_done, done);
    chk({tag, "_lines"}, o_frame_lines, lines);
    chk({tag, "_lerr"},  o_line_err, lerr);
    chk({tag, "_ferr"},  o_frame_err, ferr);
    chk({tag, "_count"}, o_frame_count, count);
  endtask

  initial begin
    string s;
    logic [31:0] c;
    for (int b = 0; b < 256; b++) begin
      c = 32'(b) << 24;
      for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
      tbl[b] = c;
    end
    s = "123456789";
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 9; i++) c = crc_byte(c, s[i]);
    chk("model_check_value", c, 32'h0376E6E7);

    @(negedge clk);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, '0);
    chk("post_rst_count", o_frame_count, 0);

    boundary(0); lit("first", 0, 0, 0, 0, 0);
    body(V, -1, 0, -1, 0);
    boundary(0); lit("clean1", 1, 12, 0, 0, 1);
    body(V, -1, 0, -1, 0);
    boundary(0); lit("clean2", 1, 12, 0, 0, 2);
    chk("zero_frames_same_crc", o_frame_crc, frame_crc_pre(V, -1, 0));
    body(V, 5, 1, -1, 0);
`ifdef VGA_FRAME_CHECKER_EXPECT_EN
    exp_crc_in = frame_crc_pre(V, 5, 1);
`endif
    boundary(0); lit("shortline", 1, 12, 1, 0, 3);
`ifdef VGA_FRAME_CHECKER_EXPECT_EN
    chk("expect_match", o_crc_mismatch, 0);
`endif
    body(V, -1, 1, -1, 1);
`ifdef VGA_FRAME_CHECKER_EXPECT_EN
    exp_crc_in = frame_crc_pre(V, -1, 1);
`endif
    boundary(0); lit("recover", 1, 12, 0, 0, 4);
`ifdef VGA_FRAME_CHECKER_EXPECT_EN
    chk("expect_flip", o_crc_mismatch, 1);
`endif
    body(V - 1, -1, 1, -1, 0);
    boundary(0); lit("fewlines", 1, 11, 0, 1, 5);
    body(V, -1, 1, -1, 0);
    boundary(1); lit("bpix_old", 1, 12, 0, 0, 6);
    chk("bpix_old_crc", o_frame_crc, frame_crc_pre(V, -1, 1));
    body(V, -1, 1, -1, 0);
    boundary(0); lit("bpix_new", 1, 13, 1, 1, 7);
    body(V, -1, 1, 6, 0);
    chk("midrst_count", o_frame_count, 0);
    boundary(0); lit("postrst_first", 0, 0, 0, 0, 0);
    body(V, -1, 0, -1, 0);
    boundary(0); lit("postrst_second", 1, 12, 0, 0, 1);
    body(2, -1, 0, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_frame_checker.md
Name: vga_frame_checker

Overview:
- Synthesizable in-line monitor on the VGA pixel stream, clocked by the pixel clock.
- Per frame, it computes a CRC-32 over active pixels, checks active-area geometry and counts frames.
- Generalised successor of the bench-side frame dump: the RGB widths, resolution and sync polarity are all parameters.
- Sits beside the VGA timing/pixel pipeline and is used both on silicon (via debug registers) and in simulation as a self-checking monitor.

Parameters:
- H_ACTIVE, 640, expected active pixels per line
- V_ACTIVE, 480, expected active lines per frame
- RW, 5, red width
- GW, 6, green width
- BW, 5, blue width
- CW, 12, width of the pixel and line counters (must satisfy 2^CW > max(H_ACTIVE, V_ACTIVE))
- VSYNC_POL, 0, vsync polarity: 0 = active-low, 1 = active-high
- FCW, 16, frame counter width

Ports:
- pclk  in  1  pixel clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- vsync  in  1  vertical sync, polarity per VSYNC_POL
- hactive  in  1  horizontal active qualifier
- vactive  in  1  vertical active qualifier
- red  in  RW  pixel red
- green  in  GW  pixel green
- blue  in  BW  pixel blue
- frame_done  out  1  one-cycle pulse when a frame's results are latched
- frame_crc  out  32  CRC of the last complete frame
- frame_lines  out  CW  active line count of the last complete frame
- line_err  out  1  sticky-per-frame: some line in the last frame had pixel count != H_ACTIVE
- frame_err  out  1  last frame's line count != V_ACTIVE
- frame_count  out  FCW  number of complete frames reported, wraps

Behaviour:
- Reset (async assert, sync release): all outputs 0; internal CRC = 0xFFFFFFFF; counters 0; state WAIT_SYNC.
- pix_valid = hactive & vactive. Pixel word P = {red, green, blue}, width PW = RW+GW+BW.
- Frame boundary: the cycle on which vsync transitions into its asserted level. Detect with a registered vsync; compare the current sample against the previous one, with polarity per VSYNC_POL.
- State WAIT_SYNC:
  - Ignore pixels.
  - On a boundary, clear the accumulators and go to CAPTURE; do not pulse frame_done (the first frame after reset is partial).
- State CAPTURE, each cycle:
  - If pix_valid: CRC absorbs P, MSB first. The polynomial is 0x04C11DB7, non-reflected, with no final XOR. All PW bits are processed in one cycle by a parallel update. pix_cnt increments.
  - Line end is the falling edge of pix_valid (registered pix_valid = 1, current = 0). On a line end:
    - line_cnt += 1.
    - If pix_cnt != H_ACTIVE, set the internal line_bad.
    - pix_cnt is cleared.
  - Counters saturate at all-ones; they do not wrap.
- Boundary in CAPTURE:
  - Latch the outputs on the next rising edge. frame_crc = current CRC state, frame_lines = line_cnt, line_err = line_bad, frame_err = (line_cnt != V_ACTIVE).
  - frame_count += 1; frame_done = 1 for exactly one cycle.
  - Accumulators reset to their init values in the same edge. Stay in CAPTURE.
- Latency: outputs are valid on the cycle frame_done is high and hold until the next frame_done.
- Simultaneous events:
  - pix_valid high on a boundary cycle: the pixel belongs to the new frame and goes into the freshly initialised CRC with pix_cnt = 1.
  - A line end on a boundary cycle counts toward the ending frame.
- A line still open at the boundary (pix_valid high on the previous cycle) is counted as a line and its pixel count is checked.
- Reset mid-frame: immediate return to WAIT_SYNC; the partial frame is discarded.

Optional Feature:
- Macro VGA_FRAME_CHECKER_EXPECT_EN.
- When defined:
  - Adds input expect_crc[31:0] and output crc_mismatch (1 bit, reset 0).
  - crc_mismatch is updated with each frame_done to (CRC != expect_crc), sampling expect_crc on the latch edge.
  - Adds a simulation-only $display of the frame number and both CRCs on a mismatch.
- When undefined: neither port exists and there is no comparator logic.

Test Plan:
- Reset, then 3 vsync pulses with correct 640x480 timing and constant pixel 16'h0000 -> no frame_done on the first boundary. Pulses on the 2nd and 3rd boundaries; frame_count = 2; frame_lines = 480; line_err = 0; frame_err = 0; frame_crc equals the bench CRC model and is identical for both frames.
- Frame in which line 100 has 639 active pixels -> line_err = 1, frame_err = 0 for that frame. The next clean frame gives line_err = 0.
- Frame with 479 active lines -> frame_lines = 479, frame_err = 1.
- Pixel valid on the exact boundary cycle with value 16'hFFFF -> the new frame's CRC matches the model with that pixel as the first word. The old frame's CRC excludes it.
- Assert reset mid-frame (line 200), release, run 2 full frames -> outputs 0 during reset; the first post-reset boundary produces no pulse; frame_count = 1 after the 2nd boundary.
- With VGA_FRAME_CHECKER_EXPECT_EN, VSYNC_POL = 1 and RW = GW = BW = 8: set expect_crc to the model value -> crc_mismatch = 0. Flip one bit of one pixel -> crc_mismatch = 1 on that frame_done.
